// File: rtl/sa_operand_skewer.sv
// Operand skewer feeding an N x N systolic MAC array: accepts one reduction slice per beat,
// emits row/column lanes diagonally delayed, plus per-anti-diagonal sync windows and c_lock.
module sa_operand_skewer #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    k_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N*DATA_W-1:0] a_vec,
  input  logic [N*DATA_W-1:0] b_vec,
  output logic [N*DATA_W-1:0] row_data,
  output logic [N-1:0]        row_valid,
  output logic [N*DATA_W-1:0] col_data,
  output logic [N-1:0]        col_valid,
  output logic [2*N-2:0]      sync_diag,
  output logic                c_lock,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2*N-1);

  state_e             state_q;
  logic [CNT_W-1:0]   klen_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               c_lock_q;
  logic               done_q;
  logic [2*N-2:0]     sync_q;
  logic               accept;

  assign accept   = in_valid && (state_q == STREAM);
  assign in_ready = (state_q == STREAM);
  assign busy     = (state_q != IDLE);
  assign c_lock   = c_lock_q;
  assign done     = done_q;
  assign cnt_d    = cnt_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      klen_q   <= '0;
      cnt_q    <= '0;
      c_lock_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      c_lock_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (k_len != '0) begin
              state_q  <= STREAM;
              klen_q   <= k_len;
              cnt_q    <= '0;
              c_lock_q <= 1'b1;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        STREAM: begin
          if (accept) begin
            if (cnt_d == klen_q) begin
              state_q <= DRAIN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
        end
        DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sync stays high through bubbles: it tracks STREAM, not accepted beats.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[2*N-3:0], state_q == STREAM};
    end
  end

  assign sync_diag = sync_q;

  // Row and column lane i share one valid chain; each lane has i+1 stages.
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [DATA_W-1:0] a_q [i+1];
    logic [DATA_W-1:0] b_q [i+1];
    logic [i:0]        v_q;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        v_q <= '0;
        for (int unsigned k = 0; k < i + 1; k++) begin
          a_q[k] <= '0;
          b_q[k] <= '0;
        end
      end else begin
        v_q[0] <= accept;
        if (accept) begin
          a_q[0] <= a_vec[i*DATA_W +: DATA_W];
          b_q[0] <= b_vec[i*DATA_W +: DATA_W];
        end
        for (int unsigned k = 1; k < i + 1; k++) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) begin
            a_q[k] <= a_q[k-1];
            b_q[k] <= b_q[k-1];
          end
        end
      end
    end

    assign row_data[i*DATA_W +: DATA_W] = a_q[i];
    assign col_data[i*DATA_W +: DATA_W] = b_q[i];
    assign row_valid[i] = v_q[i];
    assign col_valid[i] = v_q[i];
  end

endmodule

// File: tb/tb_sa_operand_skewer.sv
// Directed bench for sa_operand_skewer: an edge-indexed event history model checked every cycle,
// plus hand-computed timing/data literals per scenario.
module tb_sa_operand_skewer;

  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;
  localparam int W      = N*DATA_W;
  localparam int D      = 2*N-1;
  localparam int MAXC   = 4096;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] k_len = '0;
  logic             in_valid = 1'b0;
  logic [W-1:0]     a_vec = '0;
  logic [W-1:0]     b_vec = '0;
  logic             in_ready;
  logic [W-1:0]     row_data, col_data;
  logic [N-1:0]     row_valid, col_valid;
  logic [D-1:0]     sync_diag;
  logic             c_lock, busy, done;

  sa_operand_skewer #(.N(N), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec),
    .row_data(row_data), .row_valid(row_valid), .col_data(col_data), .col_valid(col_valid),
    .sync_diag(sync_diag), .c_lock(c_lock), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model history, indexed by edge number e (state visible in the cycle after edge e).
  bit           acc_h  [MAXC];
  logic [W-1:0] a_h    [MAXC];
  logic [W-1:0] b_h    [MAXC];
  bit           strm_h [MAXC];
  bit           act_h  [MAXC];
  bit           lock_h [MAXC];
  bit           done_h [MAXC];
  bit           m_active = 1'b0;
  int           m_k = 0, m_beats = 0, m_tl = -1;

  always @(posedge clk) begin
    cyc = cyc + 1;
    acc_h[cyc]  = 1'b0;
    lock_h[cyc] = 1'b0;
    done_h[cyc] = 1'b0;
    if (!reset_n) begin
      for (int x = 0; x <= cyc; x++) begin
        acc_h[x] = 1'b0; strm_h[x] = 1'b0; act_h[x] = 1'b0; lock_h[x] = 1'b0; done_h[x] = 1'b0;
      end
      m_active = 1'b0; m_tl = -1; m_beats = 0;
    end else begin
      if (!m_active) begin
        if (start && k_len != 0) begin
          m_active = 1'b1; m_k = int'(k_len); m_beats = 0; m_tl = -1; lock_h[cyc] = 1'b1;
        end else if (start) begin
          done_h[cyc] = 1'b1;
        end
      end else if (m_tl < 0) begin
        if (in_valid) begin
          acc_h[cyc] = 1'b1; a_h[cyc] = a_vec; b_h[cyc] = b_vec;
          m_beats++;
          if (m_beats == m_k) m_tl = cyc;
        end
      end else if (cyc == m_tl + 2*N) begin
        m_active = 1'b0; done_h[cyc] = 1'b1;
      end
      strm_h[cyc] = m_active && (m_tl < 0);
      act_h[cyc]  = m_active;
    end
  end

  // Observations used by the per-scenario literal checks.
  int rv0_cnt, rv3_cnt, rv0_first, rv3_first, done_cnt, done_cyc, lock_cnt, lock_cyc;
  int busy_cnt, s0_rise, s0_rise_cyc, s6_rise, s6_fall_cyc;
  logic [DATA_W-1:0] rv3_first_data;
  logic [D-1:0] prev_sync = '0;

  task automatic clear_obs();
    rv0_cnt = 0; rv3_cnt = 0; rv0_first = -1; rv3_first = -1; done_cnt = 0; done_cyc = -1;
    lock_cnt = 0; lock_cyc = -1; busy_cnt = 0; s0_rise = 0; s0_rise_cyc = -1; s6_rise = 0;
    s6_fall_cyc = -1; rv3_first_data = '0;
  endtask

  always @(posedge clk) begin
    #2;
    if (cyc >= 1 && cyc < MAXC) begin
      chk("in_ready", in_ready, strm_h[cyc]);
      chk("busy", busy, act_h[cyc]);
      chk("c_lock", c_lock, lock_h[cyc]);
      chk("done", done, done_h[cyc]);
      for (int i = 0; i < N; i++) begin
        bit ev;
        ev = (cyc - i >= 0) ? acc_h[cyc-i] : 1'b0;
        chk("row_valid", row_valid[i], ev);
        chk("col_valid", col_valid[i], ev);
        if (ev) begin
          chk("row_data", row_data[i*DATA_W +: DATA_W], a_h[cyc-i][i*DATA_W +: DATA_W]);
          chk("col_data", col_data[i*DATA_W +: DATA_W], b_h[cyc-i][i*DATA_W +: DATA_W]);
        end
      end
      for (int d = 0; d < D; d++) begin
        chk("sync_diag", sync_diag[d], (cyc - 1 - d >= 0) ? strm_h[cyc-1-d] : 1'b0);
      end
      if (row_valid[0]) begin
        rv0_cnt++;
        if (rv0_first < 0) rv0_first = cyc;
      end
      if (row_valid[3]) begin
        rv3_cnt++;
        if (rv3_first < 0) begin
          rv3_first = cyc;
          rv3_first_data = row_data[3*DATA_W +: DATA_W];
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (c_lock) begin lock_cnt++; lock_cyc = cyc; end
      if (busy) busy_cnt++;
      if (sync_diag[0] && !prev_sync[0]) begin s0_rise++; s0_rise_cyc = cyc; end
      if (sync_diag[6] && !prev_sync[6]) s6_rise++;
      if (!sync_diag[6] && prev_sync[6]) s6_fall_cyc = cyc;
      prev_sync = sync_diag;
    end
  end

  function automatic logic [W-1:0] mkvec(int beat, int mul);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DATA_W +: DATA_W] = DATA_W'((i+1)*beat*mul);
    return v;
  endfunction

  task automatic do_start(int k);
    start = 1'b1;
    k_len = CNT_W'(k);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beat(int beat);
    in_valid = 1'b1;
    a_vec = mkvec(beat, 1);
    b_vec = mkvec(beat, -3);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(int budget, string name);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (done) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: no done within %0d cycles, required done=1", name, budget);
  endtask

  task automatic chk_all_zero(string name);
    chk({name, "_in_ready"}, in_ready, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_c_lock"}, c_lock, 0);
    chk({name, "_row_valid"}, row_valid, 0);
    chk({name, "_col_valid"}, col_valid, 0);
    chk({name, "_row_data"}, row_data, 0);
    chk({name, "_col_data"}, col_data, 0);
    chk({name, "_sync_diag"}, sync_diag, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ts, tl, ts2, tl2, d1, s6f1;
    clear_obs();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Basic pass, k_len = 3
    clear_obs();
    do_start(3); ts = cyc;
    for (int b = 1; b <= 3; b++) send_beat(b);
    tl = cyc;
    wait_done(40, "basic");
    repeat (2) @(negedge clk);
    chk("basic_lock_cyc", lock_cyc, ts);
    chk("basic_rv0_first", rv0_first, ts + 1);
    chk("basic_rv3_cnt", rv3_cnt, 3);
    chk("basic_rv3_skew", rv3_first - rv0_first, 3);
    chk("basic_rv3_data", rv3_first_data, 8'd4);
    chk("basic_s6_fall", s6_fall_cyc, tl + 7);
    chk("basic_done_cyc", done_cyc, tl + 8);

    // Bubble: two idle cycles after beat 2
    clear_obs();
    do_start(4); ts = cyc;
    send_beat(1); send_beat(2);
    repeat (2) @(negedge clk);
    send_beat(3); send_beat(4);
    tl = cyc;
    wait_done(40, "bubble");
    repeat (2) @(negedge clk);
    chk("bubble_rv0_cnt", rv0_cnt, 4);
    chk("bubble_rv3_cnt", rv3_cnt, 4);
    chk("bubble_s0_rises", s0_rise, 1);
    chk("bubble_s6_rises", s6_rise, 1);
    chk("bubble_done_cyc", done_cyc, tl + 8);
    chk("bubble_tl", tl, ts + 6);

    // Handshake/ignore: in_valid in IDLE and DRAIN, start while busy
    clear_obs();
    in_valid = 1'b1; a_vec = mkvec(9, 1); b_vec = mkvec(9, 1);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    do_start(2); ts = cyc;
    start = 1'b1; k_len = 16'd7;
    send_beat(1);
    start = 1'b0;
    send_beat(2);
    tl = cyc;
    in_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    wait_done(40, "ignore");
    repeat (2) @(negedge clk);
    chk("ignore_rv0_cnt", rv0_cnt, 2);
    chk("ignore_lock_cnt", lock_cnt, 1);
    chk("ignore_done_cnt", done_cnt, 1);
    chk("ignore_done_cyc", done_cyc, tl + 8);
    chk("ignore_busy_cnt", busy_cnt, tl + 8 - ts);

    // Zero-length pass
    clear_obs();
    do_start(0); ts = cyc;
    repeat (4) @(negedge clk);
    chk("zero_done_cnt", done_cnt, 1);
    chk("zero_done_cyc", done_cyc, ts);
    chk("zero_busy_cnt", busy_cnt, 0);
    chk("zero_lock_cnt", lock_cnt, 0);
    chk("zero_s0_rise", s0_rise, 0);
    chk("zero_rv0_cnt", rv0_cnt, 0);

    // Mid-pass reset after beat 2 of 5, then a fresh k_len = 2 pass
    clear_obs();
    do_start(5);
    send_beat(1); send_beat(2);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk_all_zero("midrst");
    repeat (12) @(negedge clk);
    chk("midrst_done_cnt", done_cnt, 0);
    clear_obs();
    do_start(2); ts = cyc;
    send_beat(5); send_beat(6);
    tl = cyc;
    wait_done(40, "fresh");
    repeat (2) @(negedge clk);
    chk("fresh_lock_cyc", lock_cyc, ts);
    chk("fresh_rv0_first", rv0_first, ts + 1);
    chk("fresh_rv3_cnt", rv3_cnt, 2);
    chk("fresh_done_cyc", done_cyc, tl + 8);

    // Back-to-back: start in the done cycle
    clear_obs();
    do_start(2); ts = cyc;
    send_beat(7); send_beat(8);
    tl = cyc;
    wait_done(40, "b2b1");
    d1 = cyc;
    s6f1 = s6_fall_cyc;
    do_start(2); ts2 = cyc;
    send_beat(10); send_beat(11);
    tl2 = cyc;
    wait_done(40, "b2b2");
    repeat (2) @(negedge clk);
    chk("b2b_done1_cyc", d1, tl + 8);
    chk("b2b_lock_cnt", lock_cnt, 2);
    chk("b2b_lock2_cyc", lock_cyc, d1 + 1);
    chk("b2b_s6_fall1", s6f1, tl + 7);
    chk("b2b_s0_rise2", s0_rise_cyc, ts2 + 1);
    chk("b2b_sync_order", s6f1 < s0_rise_cyc, 1);
    chk("b2b_done2_cyc", done_cyc, tl2 + 8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
